tank_sprite_fetch: RTL and testbench

//  Per-pixel fetch/composite stage wrapped around the tank sprite palette ROM (32x32, 4-bit index, 24-bit RGB out, 1-cycle registered read).

---
 rtl/tank_gfx_pkg.sv | 22 ++
 rtl/tank_sprite_rotate.sv | 53 +++++
 rtl/tank_sprite_fetch.sv | 131 +++++++++++++
 tb/tb_tank_sprite_fetch.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/tank_gfx_pkg.sv
// rtl/tank_gfx_pkg.sv - shared constants and types for the tank sprite pipeline
//
// Purpose: colour key, default sprite size and heading encoding shared by the
//          tank, turret and shell sprite fetch stages.
// Ports:   none (package).

package tank_gfx_pkg;

  // ROM colour treated as "no pixel" (palette index 0).
  localparam logic [23:0] TRANSPARENT_KEY = 24'hFF0000;

  // Default sprite edge in pixels; must be a power of 2.
  localparam int SPRITE_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } tank_dir_t;

endpackage

// File: rtl/tank_sprite_rotate.sv
// rtl/tank_sprite_rotate.sv - maps sprite-local coordinates to rotated ROM row/column
//
// Purpose: combinational rotation of a local (row ly, col lx) inside a square
//          sprite into the source (row r, col c) of the upright ROM image.
// Ports:
//   lx   in   LW  local column inside the sprite
//   ly   in   LW  local row inside the sprite
//   dir  in   2   heading (tank_dir_t encoding)
//   r    out  LW  source row in the ROM image
//   c    out  LW  source column in the ROM image

module tank_sprite_rotate
  import tank_gfx_pkg::*;
#(
  parameter int SPRITE_W = SPRITE_W_DEFAULT,
  parameter int LW       = $clog2(SPRITE_W)
) (
  input  logic [LW-1:0] lx,
  input  logic [LW-1:0] ly,
  input  logic [1:0]    dir,
  output logic [LW-1:0] r,
  output logic [LW-1:0] c
);

  // SPRITE_W is a power of 2, so (SPRITE_W-1) - v is simply ~v in LW bits.
  always_comb begin
    r = ly;
    c = lx;
    case (tank_dir_t'(dir))
      DIR_UP: begin
        r = ly;
        c = lx;
      end
      DIR_RIGHT: begin
        r = ~lx;
        c = ly;
      end
      DIR_DOWN: begin
        r = ~ly;
        c = ~lx;
      end
      DIR_LEFT: begin
        r = lx;
        c = ~ly;
      end
      default: begin
        r = ly;
        c = lx;
      end
    endcase
  end

endmodule

// File: rtl/tank_sprite_fetch.sv
// rtl/tank_sprite_fetch.sv - per-pixel tank sprite address generation and colour keying
//
// Purpose: turns the VGA beam position into a rotated sprite ROM address, then
//          keys the ROM colour and emits a pixel aligned 3 clocks after DrawX/DrawY.
//          Tank position/heading/alive are sampled once per frame on frame_start.
// Ports:
//   Clk, Reset_n          clock, asynchronous active-low reset
//   frame_start           one-cycle pulse, latches the *_in inputs
//   tank_x_in/tank_y_in   sprite top-left corner (10 bit each)
//   tank_dir_in           heading, tank_dir_t encoding
//   tank_alive_in         0 = sprite hidden
//   DrawX, DrawY          current beam position (10 bit each)
//   read_address          ROM address (ADDR_W bits)
//   rom_data              ROM colour, registered one clock after read_address
//   pixel_valid           opaque sprite pixel for the beam position 3 clocks ago
//   pixel_rgb             sprite colour when pixel_valid, else 0

module tank_sprite_fetch
  import tank_gfx_pkg::*;
#(
  parameter int SPRITE_W  = SPRITE_W_DEFAULT,
  parameter int ADDR_W    = 19,
  parameter int BASE_ADDR = 0
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              frame_start,
  input  logic [9:0]        tank_x_in,
  input  logic [9:0]        tank_y_in,
  input  logic [1:0]        tank_dir_in,
  input  logic              tank_alive_in,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  output logic [ADDR_W-1:0] read_address,
  input  logic [23:0]       rom_data,
  output logic              pixel_valid,
  output logic [23:0]       pixel_rgb
);

  localparam int LW = $clog2(SPRITE_W);

  // Per-frame tank state
  logic [9:0]        x_q, x_d;
  logic [9:0]        y_q, y_d;
  logic [1:0]        dir_q, dir_d;
  logic              alive_q, alive_d;

  // Pipeline state
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              hit1_q, hit1_d;
  logic              hit2_q, hit2_d;
  logic              valid_q, valid_d;
  logic [23:0]       rgb_q, rgb_d;

  // Stage 0 signals
  logic [10:0]       lx, ly;
  logic              hit0;
  logic [LW-1:0]     src_r, src_c;
  logic              opaque;

  // Zero-extended 11-bit differences: a negative result sets the top bit, so
  // "0 <= d < SPRITE_W" reduces to all bits above LW being clear.
  assign lx   = {1'b0, DrawX} - {1'b0, x_q};
  assign ly   = {1'b0, DrawY} - {1'b0, y_q};
  assign hit0 = alive_q & (lx[10:LW] == '0) & (ly[10:LW] == '0);

  tank_sprite_rotate #(
    .SPRITE_W (SPRITE_W)
  ) u_rotate (
    .lx  (lx[LW-1:0]),
    .ly  (ly[LW-1:0]),
    .dir (dir_q),
    .r   (src_r),
    .c   (src_c)
  );

  // Frame latch: the pixel sampled in the frame_start cycle still sees the old
  // values because the comb path reads the _q side.
  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    dir_d   = dir_q;
    alive_d = alive_q;
    if (frame_start) begin
      x_d     = tank_x_in;
      y_d     = tank_y_in;
      dir_d   = tank_dir_in;
      alive_d = tank_alive_in;
    end
  end

  always_comb begin
    // r*SPRITE_W + c is the concatenation {r, c} since SPRITE_W = 2**LW.
    addr_d  = hit0 ? (ADDR_W'(BASE_ADDR) + ADDR_W'({src_r, src_c})) : '0;
    hit1_d  = hit0;
    // rom_data lines up with hit2_q: both are one clock behind read_address.
    hit2_d  = hit1_q;
    opaque  = hit2_q & (rom_data != TRANSPARENT_KEY);
    valid_d = opaque;
    rgb_d   = opaque ? rom_data : 24'h000000;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      x_q     <= '0;
      y_q     <= '0;
      dir_q   <= '0;
      alive_q <= 1'b0;
      addr_q  <= '0;
      hit1_q  <= 1'b0;
      hit2_q  <= 1'b0;
      valid_q <= 1'b0;
      rgb_q   <= '0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      dir_q   <= dir_d;
      alive_q <= alive_d;
      addr_q  <= addr_d;
      hit1_q  <= hit1_d;
      hit2_q  <= hit2_d;
      valid_q <= valid_d;
      rgb_q   <= rgb_d;
    end
  end

  assign read_address = addr_q;
  assign pixel_valid  = valid_q;
  assign pixel_rgb    = rgb_q;

endmodule

// File: tb/tb_tank_sprite_fetch.sv
// tb/tb_tank_sprite_fetch.sv - directed vector bench for tank_sprite_fetch

module tb_tank_sprite_fetch;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        frame_start;
  logic [9:0]  tank_x_in, tank_y_in;
  logic [1:0]  tank_dir_in;
  logic        tank_alive_in;
  logic [9:0]  DrawX, DrawY;
  logic [18:0] read_address;
  logic [23:0] rom_data = 24'h0;
  logic        pixel_valid;
  logic [23:0] pixel_rgb;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  tank_sprite_fetch dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .frame_start   (frame_start),
    .tank_x_in     (tank_x_in),
    .tank_y_in     (tank_y_in),
    .tank_dir_in   (tank_dir_in),
    .tank_alive_in (tank_alive_in),
    .DrawX         (DrawX),
    .DrawY         (DrawY),
    .read_address  (read_address),
    .rom_data      (rom_data),
    .pixel_valid   (pixel_valid),
    .pixel_rgb     (pixel_rgb)
  );

  // Known ROM image: palette index = address[3:0].
  function automatic logic [23:0] palette(input logic [3:0] i);
    case (i)
      4'd0:    palette = 24'hFF0000;
      4'd2:    palette = 24'h142608;
      default: palette = {4'h3, i, 8'hA5, 4'h0, i};
    endcase
  endfunction

  function automatic logic [23:0] rom_word(input logic [18:0] a);
    rom_word = palette(a[3:0]);
  endfunction

  function automatic logic [23:0] exp_rgb(input logic hit, input logic [18:0] a);
    if (hit && rom_word(a) != 24'hFF0000) exp_rgb = rom_word(a);
    else exp_rgb = 24'h0;
  endfunction

  // ROM model with a one-cycle registered read
  always_ff @(posedge Clk) rom_data <= rom_word(read_address);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_idle();
    DrawX = 10'd799;
    DrawY = 10'd524;
  endtask

  task automatic latch(input logic [9:0] x, input logic [9:0] y, input logic [1:0] d, input logic a);
    tank_x_in     = x;
    tank_y_in     = y;
    tank_dir_in   = d;
    tank_alive_in = a;
    frame_start   = 1'b1;
    set_idle();
    step();
    frame_start   = 1'b0;
  endtask

  // One isolated pixel surrounded by idle beam positions; checks the address
  // one clock later and the keyed colour exactly three clocks later.
  task automatic run_pixel(input string name, input logic [9:0] dx, input logic [9:0] dy,
                           input logic hit, input logic [18:0] addr);
    logic [23:0] rgb;
    rgb = exp_rgb(hit, addr);
    DrawX = dx;
    DrawY = dy;
    step();
    check({name, "_addr"}, read_address, addr);
    set_idle();
    step();
    check({name, "_early"}, pixel_valid, 1'b0);
    step();
    check({name, "_valid"}, pixel_valid, rgb != 24'h0);
    check({name, "_rgb"}, pixel_rgb, rgb);
  endtask

  typedef struct {
    logic [9:0]  tx;
    logic [9:0]  ty;
    logic [1:0]  dir;
    logic        alive;
    logic [9:0]  dx;
    logic [9:0]  dy;
    logic        hit;
    logic [18:0] addr;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs[NV];

  initial begin
    vecs[0]  = '{10'd100, 10'd50, 2'd0, 1'b1, 10'd100, 10'd50, 1'b1, 19'd0};
    vecs[1]  = '{10'd100, 10'd50, 2'd0, 1'b1, 10'd131, 10'd81, 1'b1, 19'd1023};
    vecs[2]  = '{10'd100, 10'd50, 2'd0, 1'b1, 10'd132, 10'd81, 1'b0, 19'd0};
    vecs[3]  = '{10'd100, 10'd50, 2'd0, 1'b1, 10'd99,  10'd50, 1'b0, 19'd0};
    vecs[4]  = '{10'd100, 10'd50, 2'd0, 1'b1, 10'd102, 10'd50, 1'b1, 19'd2};
    vecs[5]  = '{10'd100, 10'd50, 2'd0, 1'b1, 10'd105, 10'd53, 1'b1, 19'd101};
    vecs[6]  = '{10'd100, 10'd50, 2'd0, 1'b1, 10'd100, 10'd82, 1'b0, 19'd0};
    vecs[7]  = '{10'd100, 10'd50, 2'd1, 1'b1, 10'd100, 10'd50, 1'b1, 19'd992};
    vecs[8]  = '{10'd100, 10'd50, 2'd1, 1'b1, 10'd100, 10'd51, 1'b1, 19'd993};
    vecs[9]  = '{10'd100, 10'd50, 2'd2, 1'b1, 10'd100, 10'd50, 1'b1, 19'd1023};
    vecs[10] = '{10'd100, 10'd50, 2'd2, 1'b1, 10'd103, 10'd52, 1'b1, 19'd956};
    vecs[11] = '{10'd100, 10'd50, 2'd3, 1'b1, 10'd100, 10'd50, 1'b1, 19'd31};
    vecs[12] = '{10'd100, 10'd50, 2'd3, 1'b1, 10'd103, 10'd52, 1'b1, 19'd125};
    vecs[13] = '{10'd620, 10'd50, 2'd0, 1'b1, 10'd639, 10'd50, 1'b1, 19'd19};
    vecs[14] = '{10'd620, 10'd50, 2'd0, 1'b1, 10'd651, 10'd50, 1'b1, 19'd31};
    vecs[15] = '{10'd620, 10'd50, 2'd0, 1'b1, 10'd652, 10'd50, 1'b0, 19'd0};
    vecs[16] = '{10'd620, 10'd50, 2'd0, 1'b0, 10'd639, 10'd50, 1'b0, 19'd0};
    vecs[17] = '{10'd620, 10'd50, 2'd0, 1'b0, 10'd630, 10'd60, 1'b0, 19'd0};

    Reset_n       = 1'b0;
    frame_start   = 1'b0;
    tank_x_in     = 10'd0;
    tank_y_in     = 10'd0;
    tank_dir_in   = 2'd0;
    tank_alive_in = 1'b0;
    DrawX         = 10'd2;
    DrawY         = 10'd0;

    // Reset state
    step();
    step();
    check("rst_addr", read_address, 19'd0);
    check("rst_valid", pixel_valid, 1'b0);
    check("rst_rgb", pixel_rgb, 24'h0);
    Reset_n = 1'b1;
    // alive resets to 0, so a pixel at the reset position (0,0) must not hit
    run_pixel("rst_alive", 10'd2, 10'd0, 1'b0, 19'd0);

    // Table-driven vectors
    for (int i = 0; i < NV; i++) begin
      latch(vecs[i].tx, vecs[i].ty, vecs[i].dir, vecs[i].alive);
      run_pixel($sformatf("v%0d", i), vecs[i].dx, vecs[i].dy, vecs[i].hit, vecs[i].addr);
    end

    // Frame latch boundary
    latch(10'd100, 10'd50, 2'd0, 1'b1);
    tank_x_in = 10'd200;
    run_pixel("nolatch", 10'd102, 10'd50, 1'b1, 19'd2);
    frame_start = 1'b1;
    DrawX = 10'd102;
    DrawY = 10'd50;
    step();
    check("fs_same_addr", read_address, 19'd2);
    frame_start = 1'b0;
    DrawX = 10'd202;
    step();
    check("fs_next_addr", read_address, 19'd2);
    DrawX = 10'd102;
    step();
    check("fs_old_pos_addr", read_address, 19'd0);
    check("fs_same_valid", pixel_valid, 1'b1);
    check("fs_same_rgb", pixel_rgb, 24'h142608);
    set_idle();
    step();
    check("fs_next_valid", pixel_valid, 1'b1);
    check("fs_next_rgb", pixel_rgb, 24'h142608);
    step();
    check("fs_old_pos_valid", pixel_valid, 1'b0);
    step();

    // Mid-line asynchronous reset
    latch(10'd100, 10'd50, 2'd0, 1'b1);
    DrawX = 10'd102;
    DrawY = 10'd50;
    step();
    step();
    step();
    check("pre_rst_valid", pixel_valid, 1'b1);
    check("pre_rst_addr", read_address, 19'd2);
    #3;
    Reset_n = 1'b0;
    #1;
    check("async_rst_valid", pixel_valid, 1'b0);
    check("async_rst_rgb", pixel_rgb, 24'h0);
    check("async_rst_addr", read_address, 19'd0);
    step();
    Reset_n = 1'b1;
    step();
    check("post_rst_valid", pixel_valid, 1'b0);
    latch(10'd100, 10'd50, 2'd0, 1'b1);
    run_pixel("post_rst", 10'd102, 10'd50, 1'b1, 19'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
